// File: rtl/sram_ring_pkg.sv
// Shared constants and helpers for the SRAM ring address sequencer.
// Optional build macro SRAM_RING_OVERWRITE_EN is consumed by sram_ring_addr_sequencer.
package sram_ring_pkg;

   localparam int unsigned DEF_ADDR_WIDTH = 18;
   localparam int unsigned DEF_NUM_BANKS  = 2;
   localparam int unsigned MAX_BANKS      = 64;

   // Bit width needed to index n items, never less than 1.
   function automatic int unsigned clog2_min1(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((64'd1 << w) < 64'(n)) w = w + 1;
      return w;
   endfunction

   // One-hot bank select; callers truncate to their bank count.
   function automatic logic [MAX_BANKS-1:0] bank_onehot(input int unsigned bank);
      return MAX_BANKS'(1) << bank;
   endfunction

endpackage

// File: rtl/sram_ring_addr_sequencer_if.sv
// Strobe / address bus between the logging front end, readout path and the ring sequencer.
interface sram_ring_addr_sequencer_if #(
   parameter int unsigned ADDR_WIDTH = sram_ring_pkg::DEF_ADDR_WIDTH,
   parameter int unsigned NUM_BANKS  = sram_ring_pkg::DEF_NUM_BANKS
);
   localparam int unsigned BANK_W = sram_ring_pkg::clog2_min1(NUM_BANKS);
   localparam int unsigned CNT_W  = ADDR_WIDTH + BANK_W + 1;

   logic                  W_NEXT;
   logic                  R_NEXT;
   logic                  CLR_FLAGS;
   logic [ADDR_WIDTH-1:0] W_ADDRESS_OUT;
   logic [NUM_BANKS-1:0]  W_CHIP_SELECT;
   logic [ADDR_WIDTH-1:0] R_ADDRESS_OUT;
   logic [NUM_BANKS-1:0]  R_CHIP_SELECT;
   logic [CNT_W-1:0]      COUNT;
   logic                  FULL;
   logic                  EMPTY;
   logic                  OVERFLOW;
   logic                  UNDERFLOW;

   modport master (
      output W_NEXT, R_NEXT, CLR_FLAGS,
      input  W_ADDRESS_OUT, W_CHIP_SELECT, R_ADDRESS_OUT, R_CHIP_SELECT,
      input  COUNT, FULL, EMPTY, OVERFLOW, UNDERFLOW
   );

   modport slave (
      input  W_NEXT, R_NEXT, CLR_FLAGS,
      output W_ADDRESS_OUT, W_CHIP_SELECT, R_ADDRESS_OUT, R_CHIP_SELECT,
      output COUNT, FULL, EMPTY, OVERFLOW, UNDERFLOW
   );
endinterface

// File: rtl/sram_ring_ptr.sv
// One {bank, addr} wrap-around pointer with registered address and one-hot chip select.
module sram_ring_ptr
   import sram_ring_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned NUM_BANKS  = DEF_NUM_BANKS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [NUM_BANKS-1:0]  cs
);
   localparam int unsigned BANK_W = clog2_min1(NUM_BANKS);
   localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

   logic [BANK_W-1:0]     bank;
   logic [BANK_W-1:0]     bank_nxt;
   logic [ADDR_WIDTH-1:0] addr_nxt;

   // Bank steps only when the word address rolls over; bank count need not be a power of two.
   always_comb begin
      addr_nxt = addr + ADDR_WIDTH'(1);
      bank_nxt = bank;
      if (&addr) begin
         bank_nxt = (bank == LAST_BANK) ? '0 : bank + BANK_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr <= '0;
         bank <= '0;
         cs   <= NUM_BANKS'(1);
      end else if (en) begin
         addr <= addr_nxt;
         bank <= bank_nxt;
         cs   <= NUM_BANKS'(bank_onehot(32'(bank_nxt)));
      end
   end

endmodule

// File: rtl/sram_ring_addr_sequencer.sv
// Multi-bank SRAM circular buffer: independent write/read pointers, occupancy and sticky error flags.
// Build macro SRAM_RING_OVERWRITE_EN: a write while full discards the oldest word instead of being refused.
module sram_ring_addr_sequencer
   import sram_ring_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned NUM_BANKS  = DEF_NUM_BANKS
) (
   input  logic                        CLK,
   input  logic                        RESET,
   sram_ring_addr_sequencer_if.slave   bus
);
   localparam int unsigned BANK_W = clog2_min1(NUM_BANKS);
   localparam int unsigned CNT_W  = ADDR_WIDTH + BANK_W + 1;
   localparam logic [CNT_W-1:0] DEPTH = CNT_W'(NUM_BANKS) << ADDR_WIDTH;

   logic             w_en;
   logic             r_en;
   logic             ovf_set;
   logic             udf_set;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] cnt_nxt;
   logic             full;
   logic             empty;
   logic             ovf;
   logic             udf;

   // Arbitration of the two strobes against the registered occupancy state.
   always_comb begin
      w_en    = 1'b0;
      r_en    = 1'b0;
      ovf_set = 1'b0;
      udf_set = 1'b0;
      cnt_nxt = count;
      if (bus.W_NEXT && bus.R_NEXT) begin
         if (empty) begin
            w_en    = 1'b1;
            udf_set = 1'b1;
            cnt_nxt = count + CNT_W'(1);
         end else begin
            w_en = 1'b1;
            r_en = 1'b1;
         end
      end else if (bus.W_NEXT) begin
         if (!full) begin
            w_en    = 1'b1;
            cnt_nxt = count + CNT_W'(1);
         end else begin
            ovf_set = 1'b1;
`ifdef SRAM_RING_OVERWRITE_EN
            w_en    = 1'b1;
            r_en    = 1'b1;
`endif
         end
      end else if (bus.R_NEXT) begin
         if (!empty) begin
            r_en    = 1'b1;
            cnt_nxt = count - CNT_W'(1);
         end else begin
            udf_set = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         count <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
         ovf   <= 1'b0;
         udf   <= 1'b0;
      end else begin
         count <= cnt_nxt;
         full  <= (cnt_nxt == DEPTH);
         empty <= (cnt_nxt == '0);
         ovf   <= ovf_set | (ovf & ~bus.CLR_FLAGS);
         udf   <= udf_set | (udf & ~bus.CLR_FLAGS);
      end
   end

   sram_ring_ptr #(.ADDR_WIDTH(ADDR_WIDTH), .NUM_BANKS(NUM_BANKS)) u_wptr (
      .clk  (CLK),
      .rst  (RESET),
      .en   (w_en),
      .addr (bus.W_ADDRESS_OUT),
      .cs   (bus.W_CHIP_SELECT)
   );

   sram_ring_ptr #(.ADDR_WIDTH(ADDR_WIDTH), .NUM_BANKS(NUM_BANKS)) u_rptr (
      .clk  (CLK),
      .rst  (RESET),
      .en   (r_en),
      .addr (bus.R_ADDRESS_OUT),
      .cs   (bus.R_CHIP_SELECT)
   );

   assign bus.COUNT     = count;
   assign bus.FULL      = full;
   assign bus.EMPTY     = empty;
   assign bus.OVERFLOW  = ovf;
   assign bus.UNDERFLOW = udf;

endmodule

// File: tb/tb_sram_ring_addr_sequencer.sv
// Scoreboard bench for sram_ring_addr_sequencer with a 3-bank x 4-word ring (D = 12).
module tb_sram_ring_addr_sequencer;
   localparam int unsigned AW    = 2;
   localparam int unsigned NB    = 3;
   localparam int          WORDS = 1 << AW;
   localparam int          D     = NB * WORDS;

   logic clk;
   logic rst;

   sram_ring_addr_sequencer_if #(.ADDR_WIDTH(AW), .NUM_BANKS(NB)) bus ();

   sram_ring_addr_sequencer #(.ADDR_WIDTH(AW), .NUM_BANKS(NB)) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int wa, wcs, ra, rcs, cnt;
      bit full, empty, ovf, udf;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference model: linear slot indices into the whole ring.
   int wi, ri, cnt;
   bit m_ovf, m_udf;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model_snapshot();
      exp_t e;
      e.wa    = wi % WORDS;
      e.wcs   = 1 << (wi / WORDS);
      e.ra    = ri % WORDS;
      e.rcs   = 1 << (ri / WORDS);
      e.cnt   = cnt;
      e.full  = (cnt == D);
      e.empty = (cnt == 0);
      e.ovf   = m_ovf;
      e.udf   = m_udf;
      return e;
   endfunction

   task automatic model_reset();
      wi = 0; ri = 0; cnt = 0; m_ovf = 0; m_udf = 0;
   endtask

   task automatic model_step(input bit w, input bit r, input bit c);
      bit so, su;
      so = 0; su = 0;
      if (w && r) begin
         if (cnt == 0) begin wi = (wi + 1) % D; cnt = 1; su = 1; end
         else begin wi = (wi + 1) % D; ri = (ri + 1) % D; end
      end else if (w) begin
         if (cnt < D) begin wi = (wi + 1) % D; cnt++; end
         else begin
            so = 1;
`ifdef SRAM_RING_OVERWRITE_EN
            wi = (wi + 1) % D; ri = (ri + 1) % D;
`endif
         end
      end else if (r) begin
         if (cnt > 0) begin ri = (ri + 1) % D; cnt--; end
         else su = 1;
      end
      m_ovf = so | (m_ovf & !c);
      m_udf = su | (m_udf & !c);
   endtask

   // Issue one cycle of strobes and queue the state expected after the next edge.
   task automatic step(input bit w, input bit r, input bit c);
      @(negedge clk);
      bus.W_NEXT    = w;
      bus.R_NEXT    = r;
      bus.CLR_FLAGS = c;
      model_step(w, r, c);
      sb.push_back(model_snapshot());
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_waddr"}, 32'(bus.W_ADDRESS_OUT), 0);
      chk({tag, "_wcs"},   32'(bus.W_CHIP_SELECT), 1);
      chk({tag, "_raddr"}, 32'(bus.R_ADDRESS_OUT), 0);
      chk({tag, "_rcs"},   32'(bus.R_CHIP_SELECT), 1);
      chk({tag, "_count"}, 32'(bus.COUNT), 0);
      chk({tag, "_empty"}, 32'(bus.EMPTY), 1);
      chk({tag, "_full"},  32'(bus.FULL), 0);
      chk({tag, "_ovf"},   32'(bus.OVERFLOW), 0);
      chk({tag, "_udf"},   32'(bus.UNDERFLOW), 0);
   endtask

   task automatic async_reset(input string tag);
      step(0, 0, 0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check_reset_state(tag);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   // Monitor: compare every queued expectation just after its clock edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("w_addr",  32'(bus.W_ADDRESS_OUT), 32'(e.wa));
            chk("w_cs",    32'(bus.W_CHIP_SELECT), 32'(e.wcs));
            chk("r_addr",  32'(bus.R_ADDRESS_OUT), 32'(e.ra));
            chk("r_cs",    32'(bus.R_CHIP_SELECT), 32'(e.rcs));
            chk("count",   32'(bus.COUNT), 32'(e.cnt));
            chk("full",    32'(bus.FULL), 32'(e.full));
            chk("empty",   32'(bus.EMPTY), 32'(e.empty));
            chk("ovf",     32'(bus.OVERFLOW), 32'(e.ovf));
            chk("udf",     32'(bus.UNDERFLOW), 32'(e.udf));
            chk("w_cs_onehot", 32'($onehot(bus.W_CHIP_SELECT)), 1);
            chk("r_cs_onehot", 32'($onehot(bus.R_CHIP_SELECT)), 1);
         end
      end
   end

   initial begin
      int pw, pr;
      rst = 1'b1;
      bus.W_NEXT = 1'b0;
      bus.R_NEXT = 1'b0;
      bus.CLR_FLAGS = 1'b0;
      model_reset();
      #3 check_reset_state("por");
      @(negedge clk);
      rst = 1'b0;

      // Idle, then pointers to 5/3 and reset mid-run.
      repeat (3) step(0, 0, 0);
      repeat (5) step(1, 0, 0);
      repeat (3) step(0, 1, 0);
      async_reset("midrun");

      // Bank wrap and fill.
      repeat (4) step(1, 0, 0);
      settle();
      chk("wrap4_waddr", 32'(bus.W_ADDRESS_OUT), 0);
      chk("wrap4_wcs",   32'(bus.W_CHIP_SELECT), 32'h2);
      repeat (8) step(1, 0, 0);
      settle();
      chk("fill_wcs",   32'(bus.W_CHIP_SELECT), 32'h1);
      chk("fill_full",  32'(bus.FULL), 1);
      chk("fill_count", 32'(bus.COUNT), 12);

      // Write while full, then clear flags.
      step(1, 0, 0);
      settle();
      chk("ovf_set", 32'(bus.OVERFLOW), 1);
      chk("ovf_count", 32'(bus.COUNT), 12);
`ifdef SRAM_RING_OVERWRITE_EN
      chk("ovw_waddr", 32'(bus.W_ADDRESS_OUT), 1);
      chk("ovw_raddr", 32'(bus.R_ADDRESS_OUT), 1);
`else
      chk("ovf_waddr", 32'(bus.W_ADDRESS_OUT), 0);
      chk("ovf_raddr", 32'(bus.R_ADDRESS_OUT), 0);
`endif
      step(0, 0, 1);
      settle();
      chk("ovf_clr", 32'(bus.OVERFLOW), 0);

      // Simultaneous strobes at full.
      step(1, 1, 0);
      settle();
      chk("both_full_count", 32'(bus.COUNT), 12);
      chk("both_full_ovf",   32'(bus.OVERFLOW), 0);

      // Simultaneous strobes at empty.
      async_reset("rst2");
      step(1, 1, 0);
      settle();
      chk("both_empty_waddr", 32'(bus.W_ADDRESS_OUT), 1);
      chk("both_empty_raddr", 32'(bus.R_ADDRESS_OUT), 0);
      chk("both_empty_count", 32'(bus.COUNT), 1);
      chk("both_empty_udf",   32'(bus.UNDERFLOW), 1);

      // Random stream with biased phases so the ring visits full and empty.
      for (int ph = 0; ph < 20; ph++) begin
         pw = $urandom_range(10, 90);
         pr = $urandom_range(10, 90);
         for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
                 $urandom_range(0, 15) == 0);
         end
      end
      step(0, 0, 0);
      settle();
      settle();
      chk("scoreboard_drained", 32'(sb.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
